// File: rtl/dmem_responder_if.sv
// Valid/ready request/response bundle between the core datapath (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word RAM with WAIT_CYCLES wait states, byte/half/word lanes
// and load extension. Define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CntLoad = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            capture;
  logic            cap_we_q;
  logic [AW+1:0]   cap_addr_q;
  logic [31:0]     cap_wdata_q;
  logic [2:0]      cap_funct3_q;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic [31:0]     mem [DEPTH];

  // Address bits above the RAM range are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:AW+2];

  // ---------------------------------------------------------------------------
  // Decode of the captured request
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          funct_ok;
  logic          misaligned;
  logic          acc_err;

  assign word_idx = cap_addr_q[AW+1:2];
  assign lane     = cap_addr_q[1:0];

  always_comb begin
    funct_ok = 1'b0;
    if (cap_we_q) begin
      funct_ok = cap_funct3_q inside {F3B, F3H, F3W};
    end else begin
      funct_ok = cap_funct3_q inside {F3B, F3H, F3W, F3BU, F3HU};
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((cap_funct3_q == F3H || cap_funct3_q == F3HU) && lane[0]) ||
                      ((cap_funct3_q == F3W) && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign acc_err = !funct_ok || misaligned;

  // ---------------------------------------------------------------------------
  // Read path and load extension
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign rd_word = mem[word_idx];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    unique case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    unique case (cap_funct3_q)
      F3B:     load_data = {{24{rd_byte[7]}}, rd_byte};
      F3BU:    load_data = {24'h0, rd_byte};
      F3H:     load_data = {{16{rd_half[15]}}, rd_half};
      F3HU:    load_data = {16'h0, rd_half};
      F3W:     load_data = rd_word;
      default: load_data = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path: byte enables and lane-replicated store data
  // ---------------------------------------------------------------------------
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        commit;

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = cap_wdata_q;
    unique case (cap_funct3_q)
      F3B: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{cap_wdata_q[7:0]}};
      end
      F3H: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cap_wdata_q[15:0]}};
      end
      F3W: begin
        wr_be   = 4'b1111;
        wr_data = cap_wdata_q;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = cap_wdata_q;
      end
    endcase
  end

  assign commit = (state_q == StAccess) && cap_we_q && !acc_err;

  // RAM is never reset; a reset sampled on the ACCESS closing edge suppresses the store.
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          cnt_d   = CntLoad;
          state_d = (WAIT_CYCLES > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (cap_we_q || acc_err) ? 32'h0 : load_data;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cap_we_q     <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= 32'h0;
      cap_funct3_q <= 3'b000;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (capture) begin
        cap_we_q     <= bus.req_we;
        cap_addr_q   <= bus.req_addr[AW+1:0];
        cap_wdata_q  <= bus.req_wdata;
        cap_funct3_q <= bus.req_funct3;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag, latency and hold stability.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned W     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    hs_count = 0;
  int    hs_handled = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) hs_count <= hs_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        seen = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;
  string       cur_name;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      seen = 1'b0;
    end else if (hs_count != hs_handled) begin
      check({cur_name, " valid drop"}, {31'h0, bus.rsp_valid}, 32'h0);
      check({cur_name, " ready after hs"}, {31'h0, bus.req_ready}, 32'h1);
      hs_handled = hs_count;
      seen = 1'b0;
      done_cnt++;
    end else if (bus.rsp_valid) begin
      if (!seen) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected response: got rdata=%h err=%b want none",
                   bus.rsp_rdata, bus.rsp_err);
          cur_name = "unexpected";
        end else begin
          e = sb_q.pop_front();
          cur_name = name_q.pop_front();
          check({cur_name, " rdata"}, bus.rsp_rdata, e.rdata);
          check({cur_name, " err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
          check({cur_name, " latency"}, cyc, e.acc_cyc + W + 1);
        end
        seen = 1'b1;
        hold_rdata = bus.rsp_rdata;
        hold_err = bus.rsp_err;
      end else begin
        check({cur_name, " hold rdata"}, bus.rsp_rdata, hold_rdata);
        check({cur_name, " hold err"}, {31'h0, bus.rsp_err}, {31'h0, hold_err});
        check({cur_name, " ready low in resp"}, {31'h0, bus.req_ready}, 32'h0);
      end
    end
  end

  // Issue one request (called at a negedge) and wait until its response is consumed.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] exp_rdata,
                        input logic exp_err, input string name, input int hold);
    int   waited;
    int   target;
    exp_t e;
    waited = 0;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL %s: req_ready timeout got 0 want 1", name);
      return;
    end
    target = done_cnt + 1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    if (hold > 0) bus.rsp_ready = 1'b0;
    @(negedge clk);
    e.rdata = exp_rdata;
    e.err = exp_err;
    e.acc_cyc = cyc;
    sb_q.push_back(e);
    name_q.push_back(name);
    // Scramble the request bus: the captured copy must be used.
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = 32'hFFFF_FFFC;
    bus.req_wdata  = 32'hFFFF_FFFF;
    bus.req_funct3 = 3'b010;
    if (hold > 0) begin
      repeat (W + 1 + hold) @(negedge clk);
      bus.rsp_ready = 1'b1;
    end
    waited = 0;
    while (done_cnt < target && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (done_cnt < target) begin
      total++;
      bad++;
      $display("FAIL %s: response timeout got %0d want %0d", name, done_cnt, target);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset req_ready", {31'h0, bus.req_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", {31'h0, bus.req_ready}, 32'h1);

    // Basic word store/load
    do_req(1'b1, 32'h64, 32'h19, 3'b010, 32'h0, 1'b0, "sw 0x64", 0);
    do_req(1'b0, 32'h64, 32'h0, 3'b010, 32'h19, 1'b0, "lw 0x64", 0);

    // Byte lanes
    do_req(1'b1, 32'h10, 32'h11223344, 3'b010, 32'h0, 1'b0, "sw 0x10", 0);
    do_req(1'b1, 32'h11, 32'hFFFF_FFAB, 3'b000, 32'h0, 1'b0, "sb 0x11", 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h1122AB44, 1'b0, "lw 0x10", 0);
    do_req(1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFF_FFAB, 1'b0, "lb 0x11", 0);
    do_req(1'b0, 32'h11, 32'h0, 3'b100, 32'h0000_00AB, 1'b0, "lbu 0x11", 0);
    do_req(1'b0, 32'h13, 32'h0, 3'b000, 32'h0000_0011, 1'b0, "lb 0x13", 0);

    // Halfwords
    do_req(1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0, "sw 0x20", 0);
    do_req(1'b1, 32'h22, 32'h1234_8001, 3'b001, 32'h0, 1'b0, "sh 0x22", 0);
    do_req(1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, "lh 0x22", 0);
    do_req(1'b0, 32'h22, 32'h0, 3'b101, 32'h0000_8001, 1'b0, "lhu 0x22", 0);
    do_req(1'b0, 32'h20, 32'h0, 3'b010, 32'h8001_0000, 1'b0, "lw 0x20", 0);

    // Illegal funct3 and backpressure
    do_req(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, "load f3=011", 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1, "load f3=110", 0);
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b011, 32'h0, 1'b1, "store f3=011", 0);
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1, "store f3=100", 0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h1122AB44, 1'b0, "lw 0x10 backpressure", 5);

`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(1'b1, 32'h66, 32'hCAFE_0000, 3'b010, 32'h0, 1'b1, "sw 0x66 misaligned", 0);
    do_req(1'b0, 32'h64, 32'h0, 3'b010, 32'h19, 1'b0, "lw 0x64 unchanged", 0);
    do_req(1'b0, 32'h23, 32'h0, 3'b001, 32'h0, 1'b1, "lh 0x23 misaligned", 0);
`else
    do_req(1'b0, 32'h23, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, "lh 0x23 aligned down", 0);
    do_req(1'b1, 32'h66, 32'h0000_0077, 3'b010, 32'h0, 1'b0, "sw 0x66 aligned down", 0);
    do_req(1'b0, 32'h64, 32'h0, 3'b010, 32'h77, 1'b0, "lw 0x64 after sw 0x66", 0);
`endif

    // Reset during WAIT aborts the store
    do_req(1'b1, 32'h40, 32'h1111_1111, 3'b010, 32'h0, 1'b0, "sw 0x40 old", 0);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'hDEAD_BEEF;
    bus.req_funct3 = 3'b010;
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort rsp_valid in reset", {31'h0, bus.rsp_valid}, 32'h0);
    check("abort req_ready in reset", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge clk);
      check("abort rsp_valid after", {31'h0, bus.rsp_valid}, 32'h0);
    end
    do_req(1'b0, 32'h40, 32'h0, 3'b010, 32'h1111_1111, 1'b0, "lw 0x40 after abort", 0);

    // Address wrap modulo DEPTH*4
    do_req(1'b1, 32'h400, 32'h5, 3'b010, 32'h0, 1'b0, "sw 0x400", 0);
    do_req(1'b0, 32'h000, 32'h0, 3'b010, 32'h5, 1'b0, "lw 0x000 wrap", 0);

    repeat (3) @(negedge clk);
    check("scoreboard empty", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
